// File: rtl/sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sweep_ctrl
//   Drives an external up/down counter so that its value sweeps back and
//   forth between a lower and an upper bound.  A sweep is armed by 'start'
//   (with lo_lim < hi_lim), begins with a single load of the lower bound and
//   then issues one step enable every max(div,1)+1 cycles, reversing
//   direction whenever the counter reaches either bound.  'stop' aborts the
//   sweep at any point.
//
//   Parameters
//     DIV_W    prescaler / step-period width
//
//   Ports
//     clk5m    in   system clock (5 MHz), rising edge
//     rst_n    in   asynchronous active-low reset
//     start    in   begin a sweep (honoured only in IDLE)
//     stop     in   abort a sweep (wins over start and over a step)
//     lo_lim   in   lower sweep bound, unsigned
//     hi_lim   in   upper sweep bound, unsigned
//     div      in   step period; one step every max(div,1)+1 cycles
//     cnt      in   current value of the downstream counter
//     en       out  counter step enable, one-cycle pulse
//     load     out  counter load strobe, one-cycle pulse
//     data_in  out  counter load value
//     updn     out  counter direction: 0 = increment, 1 = decrement
//     busy     out  high whenever a sweep is in progress
//     dir_chg  out  pulse coincident with the en that reverses direction
//     err      out  pulse when a start is rejected (lo_lim >= hi_lim)
//
//   Every output is a flop; the next-state logic computes the value each
//   output takes in the following cycle.
// ---------------------------------------------------------------------------
module sweep_ctrl #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk5m,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [9:0]       lo_lim,
    input  logic [9:0]       hi_lim,
    input  logic [DIV_W-1:0] div,
    input  logic [9:0]       cnt,
    output logic             en,
    output logic             load,
    output logic [9:0]       data_in,
    output logic             updn,
    output logic             busy,
    output logic             dir_chg,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN_UP = 2'd2,
        RUN_DN = 2'd3
    } state_t;

    state_t           state,   state_nx;
    logic [DIV_W-1:0] presc,   presc_nx;
    logic [DIV_W-1:0] div_q,   div_q_nx;
    logic [9:0]       lo_q,    lo_q_nx;
    logic [9:0]       hi_q,    hi_q_nx;

    logic             en_nx;
    logic             load_nx;
    logic [9:0]       data_in_nx;
    logic             updn_nx;
    logic             busy_nx;
    logic             dir_chg_nx;
    logic             err_nx;

    logic             tick;

    // Step tick: prescaler has counted up to the latched period.
    assign tick = (presc == div_q);

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            presc   <= '0;
            div_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            en      <= 1'b0;
            load    <= 1'b0;
            data_in <= '0;
            updn    <= 1'b0;
            busy    <= 1'b0;
            dir_chg <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            presc   <= presc_nx;
            div_q   <= div_q_nx;
            lo_q    <= lo_q_nx;
            hi_q    <= hi_q_nx;
            en      <= en_nx;
            load    <= load_nx;
            data_in <= data_in_nx;
            updn    <= updn_nx;
            busy    <= busy_nx;
            dir_chg <= dir_chg_nx;
            err     <= err_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        presc_nx   = presc;
        div_q_nx   = div_q;
        lo_q_nx    = lo_q;
        hi_q_nx    = hi_q;
        en_nx      = 1'b0;
        load_nx    = 1'b0;
        data_in_nx = data_in;
        updn_nx    = updn;
        dir_chg_nx = 1'b0;
        err_nx     = 1'b0;

        unique case (state)
            IDLE: begin
                presc_nx = '0;
                if (start && !stop) begin
                    if (lo_lim < hi_lim) begin
                        lo_q_nx    = lo_lim;
                        hi_q_nx    = hi_lim;
                        div_q_nx   = (div == '0) ? DIV_W'(1) : div;
                        // The load strobe is raised on entry so that it is
                        // visible for exactly the one cycle spent in LOAD.
                        load_nx    = 1'b1;
                        data_in_nx = lo_lim;
                        state_nx   = LOAD;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end

            LOAD: begin
                presc_nx = '0;
                state_nx = stop ? IDLE : RUN_UP;
            end

            RUN_UP: begin
                if (stop) begin
                    presc_nx = '0;
                    state_nx = IDLE;
                end else if (tick) begin
                    presc_nx = '0;
                    en_nx    = 1'b1;
                    if (cnt >= hi_q) begin
                        updn_nx    = 1'b1;
                        dir_chg_nx = 1'b1;
                        state_nx   = RUN_DN;
                    end else begin
                        updn_nx = 1'b0;
                    end
                end else begin
                    presc_nx = presc + DIV_W'(1);
                end
            end

            RUN_DN: begin
                if (stop) begin
                    presc_nx = '0;
                    state_nx = IDLE;
                end else if (tick) begin
                    presc_nx = '0;
                    en_nx    = 1'b1;
                    if (cnt <= lo_q) begin
                        updn_nx    = 1'b0;
                        dir_chg_nx = 1'b1;
                        state_nx   = RUN_UP;
                    end else begin
                        updn_nx = 1'b1;
                    end
                end else begin
                    presc_nx = presc + DIV_W'(1);
                end
            end

            default: begin
                presc_nx = '0;
                state_nx = IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks state != IDLE.
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sweep_ctrl
//   Directed bench for sweep_ctrl with a behavioural up/down counter attached
//   to the en/load/data_in/updn outputs and fed back on cnt.  Inputs change
//   and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sweep_ctrl;

    logic        clk5m  = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        stop   = 1'b0;
    logic [9:0]  lo_lim = '0;
    logic [9:0]  hi_lim = '0;
    logic [15:0] div    = '0;
    logic [9:0]  cnt    = '0;
    logic        en, load, updn, busy, dir_chg, err;
    logic [9:0]  data_in;

    int n_cmp = 0;
    int n_bad = 0;

    sweep_ctrl #(.DIV_W(16)) dut (
        .clk5m   (clk5m),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .lo_lim  (lo_lim),
        .hi_lim  (hi_lim),
        .div     (div),
        .cnt     (cnt),
        .en      (en),
        .load    (load),
        .data_in (data_in),
        .updn    (updn),
        .busy    (busy),
        .dir_chg (dir_chg),
        .err     (err)
    );

    // 5 MHz clock
    always #100 clk5m = ~clk5m;

    // Downstream up/down counter model
    always @(posedge clk5m) begin
        if (load)
            cnt <= data_in;
        else if (en)
            cnt <= updn ? cnt - 10'd1 : cnt + 10'd1;
    end

    // Arm a sweep; returns at the falling edge of the LOAD cycle.
    task automatic start_sweep(input logic [9:0] lo, input logic [9:0] hi,
                               input logic [15:0] d);
        @(negedge clk5m);
        lo_lim = lo;
        hi_lim = hi;
        div    = d;
        start  = 1'b1;
        @(negedge clk5m);
        start  = 1'b0;
    endtask

    // Abort the current sweep and confirm the controller is idle again.
    task automatic end_sweep(input string tag);
        @(negedge clk5m);
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk5m);
        stop  = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_stop_busy: got %0b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk5m);
        @(negedge clk5m);
        n_cmp++;
        if ({en, load, updn, busy, dir_chg, err, data_in} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {en, load, updn, busy, dir_chg, err, data_in});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk5m);
            n_cmp++;
            if ({busy, load, en} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_idle: got busy/load/en %b expected 000",
                         {busy, load, en});
            end
        end
    endtask

    task automatic test_sweep();
        logic [9:0] exp_cnt [8];
        logic [7:0] exp_updn;
        logic [7:0] exp_dir;
        logic       exp_en;
        int         k;
        exp_cnt  = '{10'd3, 10'd4, 10'd5, 10'd6, 10'd5, 10'd4, 10'd3, 10'd4};
        exp_updn = 8'b0011_1000;
        exp_dir  = 8'b0100_1000;
        k = 0;
        start_sweep(10'd3, 10'd6, 16'd1);
        n_cmp++;
        if ({load, data_in, busy, en} !== {1'b1, 10'd3, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL sweep_load: got load=%0b data_in=%0d busy=%0b en=%0b expected 1 3 1 0",
                     load, data_in, busy, en);
        end
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk5m);
            exp_en = (c >= 3) && ((c - 3) % 2 == 0);
            n_cmp++;
            if ({en, load} !== {exp_en, 1'b0}) begin
                n_bad++;
                $display("FAIL sweep_en_c%0d: got en=%0b load=%0b expected en=%0b load=0",
                         c, en, load, exp_en);
            end
            if (en && k < 8) begin
                n_cmp++;
                if ({cnt, updn, dir_chg} !== {exp_cnt[k], exp_updn[k], exp_dir[k]}) begin
                    n_bad++;
                    $display("FAIL sweep_step%0d: got cnt=%0d updn=%0b dir_chg=%0b expected %0d %0b %0b",
                             k, cnt, updn, dir_chg, exp_cnt[k], exp_updn[k], exp_dir[k]);
                end
                k++;
            end else if (!en) begin
                n_cmp++;
                if (dir_chg !== 1'b0) begin
                    n_bad++;
                    $display("FAIL sweep_dirchg_c%0d: got %0b expected 0", c, dir_chg);
                end
            end
        end
        n_cmp++;
        if (k !== 8) begin
            n_bad++;
            $display("FAIL sweep_step_count: got %0d expected 8", k);
        end
        end_sweep("sweep");
    endtask

    task automatic test_err();
        int errs;
        errs = 0;
        @(negedge clk5m);
        lo_lim = 10'd5;
        hi_lim = 10'd5;
        div    = 16'd1;
        start  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk5m);
            start = 1'b0;
            if (err) errs++;
            n_cmp++;
            if ({busy, load, en} !== 3'b000) begin
                n_bad++;
                $display("FAIL err_quiet_c%0d: got busy/load/en %b expected 000",
                         i, {busy, load, en});
            end
        end
        n_cmp++;
        if (errs !== 1) begin
            n_bad++;
            $display("FAIL err_pulses: got %0d expected 1", errs);
        end
    endtask

    task automatic test_div0();
        int prev;
        int first;
        int nen;
        prev  = -1;
        first = -1;
        nen   = 0;
        start_sweep(10'd0, 10'd2, 16'd0);
        n_cmp++;
        if ({load, data_in} !== {1'b1, 10'd0}) begin
            n_bad++;
            $display("FAIL div0_load: got load=%0b data_in=%0d expected 1 0", load, data_in);
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk5m);
            if (en) begin
                if (first < 0) first = c;
                if (prev >= 0) begin
                    n_cmp++;
                    if (c - prev !== 2) begin
                        n_bad++;
                        $display("FAIL div0_spacing: got %0d expected 2", c - prev);
                    end
                end
                prev = c;
                nen++;
            end
        end
        n_cmp++;
        if ({first, nen} !== {32'sd3, 32'sd5}) begin
            n_bad++;
            $display("FAIL div0_count: got first=%0d n=%0d expected 3 5", first, nen);
        end
        end_sweep("div0");
    endtask

    task automatic test_stop_tick();
        start_sweep(10'd3, 10'd6, 16'd1);
        for (int c = 1; c <= 3; c++) @(negedge clk5m);
        n_cmp++;
        if ({en, cnt} !== {1'b1, 10'd3}) begin
            n_bad++;
            $display("FAIL stoptick_pre_en: got en=%0b cnt=%0d expected 1 3", en, cnt);
        end
        @(negedge clk5m);
        n_cmp++;
        if ({cnt, busy} !== {10'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL stoptick_at_tick: got cnt=%0d busy=%0b expected 4 1", cnt, busy);
        end
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk5m);
        stop  = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({en, busy, load} !== 3'b000) begin
            n_bad++;
            $display("FAIL stoptick_after: got en/busy/load %b expected 000", {en, busy, load});
        end
        @(negedge clk5m);
        n_cmp++;
        if ({cnt, busy} !== {10'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL stoptick_cnt: got cnt=%0d busy=%0b expected 4 0", cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        start_sweep(10'd3, 10'd6, 16'd1);
        for (int c = 1; c <= 10; c++) @(negedge clk5m);
        n_cmp++;
        if ({busy, updn} !== 2'b11) begin
            n_bad++;
            $display("FAIL rstmid_in_dn: got busy/updn %b expected 11", {busy, updn});
        end
        #20 rst_n = 1'b0;
        #5;
        n_cmp++;
        if ({en, load, updn, busy, dir_chg, err, data_in} !== 16'h0000) begin
            n_bad++;
            $display("FAIL rstmid_async: got %h expected 0000",
                     {en, load, updn, busy, dir_chg, err, data_in});
        end
        @(negedge clk5m);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk5m);
            n_cmp++;
            if ({busy, load, en} !== 3'b000) begin
                n_bad++;
                $display("FAIL rstmid_idle_c%0d: got busy/load/en %b expected 000",
                         i, {busy, load, en});
            end
        end
        start_sweep(10'd1, 10'd2, 16'd1);
        n_cmp++;
        if ({load, data_in, busy} !== {1'b1, 10'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL rstmid_reload: got load=%0b data_in=%0d busy=%0b expected 1 1 1",
                     load, data_in, busy);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk5m);
            if (c == 3) begin
                n_cmp++;
                if ({en, cnt, updn, dir_chg} !== {1'b1, 10'd1, 1'b0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL rstmid_step0: got en=%0b cnt=%0d updn=%0b dir_chg=%0b expected 1 1 0 0",
                             en, cnt, updn, dir_chg);
                end
            end else if (c == 5) begin
                n_cmp++;
                if ({en, cnt, updn, dir_chg} !== {1'b1, 10'd2, 1'b1, 1'b1}) begin
                    n_bad++;
                    $display("FAIL rstmid_step1: got en=%0b cnt=%0d updn=%0b dir_chg=%0b expected 1 2 1 1",
                             en, cnt, updn, dir_chg);
                end
            end
        end
        end_sweep("rstmid");
    endtask

    task automatic test_ignore();
        logic [9:0] exp_cnt [7];
        logic [6:0] exp_updn;
        logic [6:0] exp_dir;
        logic       exp_en;
        int         k;
        exp_cnt  = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd2, 10'd1, 10'd0};
        exp_updn = 7'b011_1000;
        exp_dir  = 7'b100_1000;
        k = 0;
        start_sweep(10'd0, 10'd3, 16'd1);
        n_cmp++;
        if ({load, data_in} !== {1'b1, 10'd0}) begin
            n_bad++;
            $display("FAIL ignore_load: got load=%0b data_in=%0d expected 1 0", load, data_in);
        end
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk5m);
            exp_en = (c >= 3) && ((c - 3) % 2 == 0);
            n_cmp++;
            if ({en, load} !== {exp_en, 1'b0}) begin
                n_bad++;
                $display("FAIL ignore_en_c%0d: got en=%0b load=%0b expected en=%0b load=0",
                         c, en, load, exp_en);
            end
            if (en && k < 7) begin
                n_cmp++;
                if ({cnt, updn, dir_chg} !== {exp_cnt[k], exp_updn[k], exp_dir[k]}) begin
                    n_bad++;
                    $display("FAIL ignore_step%0d: got cnt=%0d updn=%0b dir_chg=%0b expected %0d %0b %0b",
                             k, cnt, updn, dir_chg, exp_cnt[k], exp_updn[k], exp_dir[k]);
                end
                k++;
            end
            // Disturb the sweep inputs while busy.
            start  = (c % 2 == 1);
            hi_lim = (c % 2 == 1) ? 10'd7 : 10'd1;
            lo_lim = (c % 2 == 1) ? 10'd2 : 10'd0;
            div    = 16'(c % 3 + 3);
        end
        n_cmp++;
        if (k !== 7) begin
            n_bad++;
            $display("FAIL ignore_step_count: got %0d expected 7", k);
        end
        end_sweep("ignore");
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_err();
        test_div0();
        test_stop_tick();
        test_reset_mid();
        test_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
